counter_cascade: RTL and testbench

Parametrised synchronous counter built from a cascade of 4-bit stages, with load, start/stop, up/down direction and a programmable wrap limit. It is the general-width successor to the team's fixed 8-bit cascaded counter. It is used wherever a timer, event counter or modulo divider of arbitrary nibble-multiple width is needed.

---
 rtl/counter_pkg.sv | 13 +
 rtl/counter_nibble.sv | 42 ++++
 rtl/counter_cascade.sv | 75 +++++++
 tb/tb_counter_cascade.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the nibble-cascade counter family.
package counter_pkg;

    localparam int unsigned NIBBLE_W = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic int unsigned num_stages(input int unsigned width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/counter_nibble.sv
// One 4-bit counter stage: clear > load > carry-in step; carry-out flags the terminal value.
module counter_nibble
    import counter_pkg::*;
(
    input  logic                clock,
    input  logic                clear,
    input  logic                load,
    input  logic                carry_in,
    input  logic                dir,
    input  logic [NIBBLE_W-1:0] d,
    output logic [NIBBLE_W-1:0] q,
    output logic                carry_out
);

    logic [NIBBLE_W-1:0] q_q, q_d;
    logic                terminal;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (carry_in) begin
            q_d = (dir == DIR_UP) ? q_q + 4'd1 : q_q - 4'd1;
        end
    end

    always_comb begin
        terminal  = (dir == DIR_DOWN) ? (q_q == '0) : (q_q == '1);
        carry_out = carry_in & terminal;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/counter_cascade.sv
// WIDTH-bit counter built from WIDTH/4 nibble stages with load, enable and wrap limit.
// Down counting is built only when COUNTER_CASCADE_DOWN_EN is defined; otherwise up-only.
module counter_cascade
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic             start_stop,
    input  logic             up_down,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam int unsigned STAGES = num_stages(WIDTH);

    logic             dir;
    logic [WIDTH-1:0] count_q;
    logic [STAGES:0]  carry;
    logic             wrap_hit;
    logic             rollover;
    logic             force_load;
    logic [WIDTH-1:0] load_val;
    logic             wrap_q, wrap_d;
    logic             unused_carry;

`ifdef COUNTER_CASCADE_DOWN_EN
    assign dir = up_down;
`else
    logic unused_up_down;
    assign unused_up_down = up_down;
    assign dir            = DIR_UP;
`endif

    always_comb begin
        wrap_hit   = start_stop & ((dir == DIR_UP) ? (count_q == limit) : (count_q == '0));
        // A count loaded above limit still pulses wrap on its natural 2^WIDTH rollover.
        rollover   = start_stop & (dir == DIR_UP) & (count_q == '1);
        force_load = load | wrap_hit;
        load_val   = load ? data : ((dir == DIR_UP) ? '0 : limit);
        wrap_d     = ~load & (wrap_hit | rollover);
    end

    assign carry[0]     = start_stop;
    assign unused_carry = carry[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        counter_nibble u_stage (
            .clock     (clock),
            .clear     (clear),
            .load      (force_load),
            .carry_in  (carry[k]),
            .dir       (dir),
            .d         (load_val[k*NIBBLE_W +: NIBBLE_W]),
            .q         (count_q[k*NIBBLE_W +: NIBBLE_W]),
            .carry_out (carry[k+1])
        );
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_counter_cascade.sv
// Scoreboard bench for counter_cascade (WIDTH=16): driver queues expectations, monitor checks.
module tb_counter_cascade;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        load = 1'b0;
    logic        start_stop = 1'b0;
    logic        up_down = 1'b1;
    logic [15:0] limit = 16'hFFFF;
    logic [15:0] data = 16'h0000;
    logic [15:0] count;
    logic        wrap;

    typedef struct {
        int          due;
        logic [15:0] cnt;
        logic        wrp;
        string       name;
    } exp_t;

    exp_t  sb[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;
    string tname = "reset";

    counter_cascade #(.WIDTH(16)) dut (
        .clock      (clock),
        .clear      (clear),
        .load       (load),
        .start_stop (start_stop),
        .up_down    (up_down),
        .limit      (limit),
        .data       (data),
        .count      (count),
        .wrap       (wrap)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Drive one cycle of inputs at the falling edge; expectation is due after the next rise.
    task automatic drive(input logic clr, input logic ld, input logic ss, input logic ud,
                         input logic [15:0] lim, input logic [15:0] dat,
                         input logic [15:0] exp_c, input logic exp_w);
        exp_t e;
        @(negedge clock);
        clear      = clr;
        load       = ld;
        start_stop = ss;
        up_down    = ud;
        limit      = lim;
        data       = dat;
        e.due  = cyc + 1;
        e.cnt  = exp_c;
        e.wrp  = exp_w;
        e.name = tname;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (count === e.cnt && wrap === e.wrp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s @cyc %0d: count=%h wrap=%b, expected count=%h wrap=%b",
                             e.name, cyc, count, wrap, e.cnt, e.wrp);
                end
            end
        end
    end

    initial begin : stimulus
        // Reset held for three cycles.
        tname = "reset";
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 16'hFFFF, 16'h0, 16'h0000, 0);

        // Clear mid-count at 0x1234 beats load and start_stop, then resumes from 0.
        tname = "clear_mid";
        drive(0, 1, 0, 1, 16'hFFFF, 16'h1233, 16'h1233, 0);
        drive(0, 0, 1, 1, 16'hFFFF, 16'h0, 16'h1234, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 0);
        drive(0, 0, 1, 1, 16'hFFFF, 16'h0, 16'h0001, 0);

        // Carry across nibble boundaries.
        tname = "cascade";
        drive(0, 1, 0, 1, 16'hFFFF, 16'h00FE, 16'h00FE, 0);
        drive(0, 0, 1, 1, 16'hFFFF, 16'h0, 16'h00FF, 0);
        drive(0, 0, 1, 1, 16'hFFFF, 16'h0, 16'h0100, 0);
        drive(0, 1, 0, 1, 16'hFFFF, 16'h0FFF, 16'h0FFF, 0);
        drive(0, 0, 1, 1, 16'hFFFF, 16'h0, 16'h1000, 0);

        // Limit 5: period of 6 with wrap only on the 0 cycle.
        tname = "limit5";
        drive(1, 0, 0, 1, 16'h0005, 16'h0, 16'h0000, 0);
        for (int i = 1; i <= 12; i++)
            drive(0, 0, 1, 1, 16'h0005, 16'h0, 16'(i % 6), (i % 6) == 0);

        // Load wins over start_stop, then hold.
        tname = "load_vs_step";
        drive(0, 1, 1, 1, 16'hFFFF, 16'hABCD, 16'hABCD, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 16'hFFFF, 16'h0, 16'hABCD, 0);

        // Limit 0: wrap every enabled cycle, dropped when stopped.
        tname = "limit0";
        drive(0, 1, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 16'h0000, 16'h0, 16'h0000, 1);
        drive(0, 0, 0, 1, 16'h0000, 16'h0, 16'h0000, 0);

        // Loaded above limit: natural rollover to 0 also pulses wrap.
        tname = "above_limit";
        drive(0, 1, 0, 1, 16'h0005, 16'hFFF0, 16'hFFF0, 0);
        for (int i = 1; i <= 15; i++)
            drive(0, 0, 1, 1, 16'h0005, 16'h0, 16'hFFF0 + 16'(i), 0);
        drive(0, 0, 1, 1, 16'h0005, 16'h0, 16'h0000, 1);
        drive(0, 0, 1, 1, 16'h0005, 16'h0, 16'h0001, 0);

`ifdef COUNTER_CASCADE_DOWN_EN
        // Down counting wraps from 0 to limit.
        tname = "down";
        drive(1, 0, 0, 0, 16'h0003, 16'h0, 16'h0000, 0);
        drive(0, 1, 0, 0, 16'h0003, 16'h0001, 16'h0001, 0);
        drive(0, 0, 1, 0, 16'h0003, 16'h0, 16'h0000, 0);
        drive(0, 0, 1, 0, 16'h0003, 16'h0, 16'h0003, 1);
        drive(0, 0, 1, 0, 16'h0003, 16'h0, 16'h0002, 0);
        drive(0, 0, 1, 0, 16'h0003, 16'h0, 16'h0001, 0);
        drive(0, 0, 1, 0, 16'h0003, 16'h0, 16'h0000, 0);
        drive(0, 0, 1, 0, 16'h0003, 16'h0, 16'h0003, 1);
        // Direction flip at count==limit takes effect on this edge.
        drive(0, 0, 1, 1, 16'h0003, 16'h0, 16'h0000, 1);
        // Borrow across nibbles.
        tname = "down_borrow";
        drive(0, 1, 0, 0, 16'hFFFF, 16'h0100, 16'h0100, 0);
        drive(0, 0, 1, 0, 16'hFFFF, 16'h0, 16'h00FF, 0);
        drive(0, 0, 1, 0, 16'hFFFF, 16'h0, 16'h00FE, 0);
`else
        // up_down ignored: still counts up.
        tname = "up_only";
        drive(0, 1, 0, 0, 16'hFFFF, 16'h0010, 16'h0010, 0);
        drive(0, 0, 1, 0, 16'hFFFF, 16'h0, 16'h0011, 0);
        drive(0, 0, 1, 0, 16'hFFFF, 16'h0, 16'h0012, 0);
        drive(0, 1, 0, 0, 16'h0005, 16'hFFF0, 16'hFFF0, 0);
        for (int i = 1; i <= 15; i++)
            drive(0, 0, 1, 0, 16'h0005, 16'h0, 16'hFFF0 + 16'(i), 0);
        drive(0, 0, 1, 0, 16'h0005, 16'h0, 16'h0000, 1);
`endif

        tname = "final_hold";
        drive(0, 0, 0, 1, 16'hFFFF, 16'h0, count_after_last(), 0);

        repeat (4) @(negedge clock);
        n_checks++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Count value the last scripted step leaves behind (constant per build).
    function automatic logic [15:0] count_after_last();
`ifdef COUNTER_CASCADE_DOWN_EN
        return 16'h00FE;
`else
        return 16'h0000;
`endif
    endfunction

endmodule
